// File: rtl/tetris_game_ctrl.sv
// tetris_game_ctrl: game-level sequencer for the Tetris datapath.
// It spawns pieces, generates gravity ticks and decides when a landed piece locks.
// It then steps the board through a lock write and a bottom-up full-row scan/shift,
// and it flags game over when a new piece cannot spawn.
module tetris_game_ctrl #(
  parameter int unsigned TICK_DIV        = 3500000,
  parameter int unsigned ROWS            = 24,
  parameter int unsigned LOCK_DELAY      = 2,
  parameter int unsigned SPEED_INIT      = 5,
  parameter int unsigned LINES_PER_LEVEL = 10
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_N,
  input  logic        start_n,
  input  logic [3:0]  rand_in,
  input  logic        landed,
  input  logic        spawn_blocked,
  input  logic        lock_done,
  input  logic        row_full,
  input  logic        shift_done,
  output logic [3:0]  shape,
  output logic [3:0]  next_shape,
  output logic        change_shape,
  output logic        start_over,
  output logic        clear,
  output logic        gravity_tick,
  output logic        lock_req,
  output logic [4:0]  row_addr,
  output logic        shift_req,
  output logic [4:0]  shift_row,
  output logic [4:0]  speed,
  output logic [15:0] lines,
  output logic        game_over,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SPAWN     = 3'd1,
    S_SPAWN_CHK = 3'd2,
    S_FALL      = 3'd3,
    S_LOCK      = 3'd4,
    S_SCAN      = 3'd5,
    S_SHIFT     = 3'd6,
    S_GAMEOVER  = 3'd7
  } state_e;

  localparam int unsigned   TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [4:0]    ROW_TOP   = 5'(ROWS - 1);
  localparam logic [4:0]    SPEED_RST = 5'(SPEED_INIT);
  localparam logic [2:0]    LOCK_LIM  = 3'(LOCK_DELAY);

  // LFSR codes above 14 have no piece; they fall back to the square.
  function automatic logic [3:0] map_shape(input logic [3:0] r);
    if (r <= 4'd14) begin
      return r;
    end else begin
      return 4'd0;
    end
  endfunction

  // One level step adds 2 to the fall speed, pinned at the 5-bit maximum.
  function automatic logic [4:0] speed_step(input logic [4:0] s);
    if (s >= 5'd29) begin
      return 5'd31;
    end else begin
      return s + 5'd2;
    end
  endfunction

  state_e        state_q;
  logic          start_prev_q;
  logic [TW-1:0] tick_cnt_q;
  logic [2:0]    lock_cnt_q;
  logic [3:0]    shape_q;
  logic [3:0]    next_shape_q;
  logic          change_shape_q;
  logic          start_over_q;
  logic          clear_q;
  logic          gravity_tick_q;
  logic          lock_req_q;
  logic          shift_req_q;
  logic [4:0]    row_addr_q;
  logic [4:0]    shift_row_q;
  logic [4:0]    speed_q;
  logic [15:0]   lines_q;
  logic          game_over_q;

  logic          start_evt_s;
  logic          tick_hit_s;
  logic          spawn_go_s;
  logic          lines_max_s;
  logic          level_up_s;
  logic [2:0]    lock_inc_s;
  logic [15:0]   lines_inc_s;

  // Decode start edge, gravity tick, spawn entry and line/level arithmetic.
  always_comb begin
    start_evt_s = start_prev_q & ~start_n;
    tick_hit_s  = (state_q == S_FALL) && (tick_cnt_q == TICK_LAST);
    lock_inc_s  = lock_cnt_q + 3'd1;
    lines_max_s = (lines_q == 16'hFFFF);
    lines_inc_s = lines_q + 16'd1;
    level_up_s  = !lines_max_s && ((32'(lines_inc_s) % LINES_PER_LEVEL) == 32'd0);
    spawn_go_s  = 1'b0;
    case (state_q)
      S_IDLE, S_GAMEOVER: spawn_go_s = start_evt_s;
      S_SCAN:             spawn_go_s = !row_full && (row_addr_q == 5'd0);
      default:            spawn_go_s = 1'b0;
    endcase
  end

  // Game sequencer: state, tick counter, board handshakes and all registered outputs.
  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q        <= S_IDLE;
      start_prev_q   <= 1'b1;
      tick_cnt_q     <= '0;
      lock_cnt_q     <= 3'd0;
      shape_q        <= 4'd0;
      next_shape_q   <= 4'd0;
      change_shape_q <= 1'b0;
      start_over_q   <= 1'b0;
      clear_q        <= 1'b0;
      gravity_tick_q <= 1'b0;
      lock_req_q     <= 1'b0;
      shift_req_q    <= 1'b0;
      row_addr_q     <= 5'd0;
      shift_row_q    <= 5'd0;
      speed_q        <= SPEED_RST;
      lines_q        <= 16'd0;
      game_over_q    <= 1'b0;
    end else begin
      start_prev_q   <= start_n;
      change_shape_q <= 1'b0;
      start_over_q   <= 1'b0;
      clear_q        <= 1'b0;
      gravity_tick_q <= 1'b0;

      // The tick counter only runs in FALL, so every FALL entry starts from zero.
      if ((state_q == S_FALL) && !tick_hit_s) begin
        tick_cnt_q <= tick_cnt_q + TW'(1);
      end else begin
        tick_cnt_q <= '0;
      end

      case (state_q)
        S_IDLE, S_GAMEOVER: begin
          if (start_evt_s) begin
            lines_q     <= 16'd0;
            speed_q     <= SPEED_RST;
            game_over_q <= 1'b0;
            state_q     <= S_SPAWN;
          end else begin
            state_q <= state_q;
          end
        end
        S_SPAWN: begin
          state_q <= S_SPAWN_CHK;
        end
        S_SPAWN_CHK: begin
          lock_cnt_q <= 3'd0;
          if (spawn_blocked) begin
            game_over_q <= 1'b1;
            state_q     <= S_GAMEOVER;
          end else begin
            state_q <= S_FALL;
          end
        end
        S_FALL: begin
          if (tick_hit_s) begin
            gravity_tick_q <= 1'b1;
            if (landed) begin
              lock_cnt_q <= lock_inc_s;
              if (lock_inc_s == LOCK_LIM) begin
                lock_req_q <= 1'b1;
                state_q    <= S_LOCK;
              end else begin
                state_q <= S_FALL;
              end
            end else begin
              lock_cnt_q <= 3'd0;
            end
          end else begin
            state_q <= S_FALL;
          end
        end
        S_LOCK: begin
          if (lock_done) begin
            lock_req_q <= 1'b0;
            row_addr_q <= ROW_TOP;
            state_q    <= S_SCAN;
          end else begin
            lock_req_q <= 1'b1;
          end
        end
        S_SCAN: begin
          if (row_full) begin
            shift_row_q <= row_addr_q;
            shift_req_q <= 1'b1;
            state_q     <= S_SHIFT;
          end else if (row_addr_q == 5'd0) begin
            state_q <= S_SPAWN;
          end else begin
            row_addr_q <= row_addr_q - 5'd1;
          end
        end
        S_SHIFT: begin
          // Row index is kept so the row that dropped into place is checked next.
          if (shift_done) begin
            shift_req_q <= 1'b0;
            clear_q     <= 1'b1;
            if (!lines_max_s) begin
              lines_q <= lines_inc_s;
            end else begin
              lines_q <= lines_q;
            end
            if (level_up_s) begin
              speed_q <= speed_step(speed_q);
            end else begin
              speed_q <= speed_q;
            end
            state_q <= S_SCAN;
          end else begin
            shift_req_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // Loading a new piece: promote the preview, draw a fresh one, pulse the mover.
      if (spawn_go_s) begin
        shape_q        <= next_shape_q;
        next_shape_q   <= map_shape(rand_in);
        change_shape_q <= 1'b1;
        start_over_q   <= 1'b1;
      end else begin
        shape_q <= shape_q;
      end
    end
  end

  assign shape        = shape_q;
  assign next_shape   = next_shape_q;
  assign change_shape = change_shape_q;
  assign start_over   = start_over_q;
  assign clear        = clear_q;
  assign gravity_tick = gravity_tick_q;
  assign lock_req     = lock_req_q;
  assign row_addr     = row_addr_q;
  assign shift_req    = shift_req_q;
  assign shift_row    = shift_row_q;
  assign speed        = speed_q;
  assign lines        = lines_q;
  assign game_over    = game_over_q;
  assign state        = state_q;

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// tb_tetris_game_ctrl: randomized self-checking bench for tetris_game_ctrl.
// The bench plays the board (row occupancy array with real row removal) and
// predicts outputs from the game rules: consecutive landed ticks, removed-row
// positions, line count and the speed-per-level formula.
module tb_tetris_game_ctrl;

  localparam int TICK_DIV = 4;
  localparam int ROWS     = 24;
  localparam int LOCK_DLY = 2;
  localparam int SPD_INIT = 5;
  localparam int LPL      = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_n;
  logic [3:0]  rand_in;
  logic        landed, spawn_blocked, lock_done, row_full, shift_done;
  logic [3:0]  shape, next_shape;
  logic        change_shape, start_over, clear, gravity_tick, lock_req, shift_req, game_over;
  logic [4:0]  row_addr, shift_row, speed;
  logic [15:0] lines;
  logic [2:0]  state;

  logic [ROWS-1:0] board;
  int n_checks = 0;
  int n_fail   = 0;
  int exp_lines;
  logic [3:0] exp_next;

  always #5 clk = ~clk;

  assign row_full = (int'(row_addr) < ROWS) ? board[row_addr] : 1'b0;

  tetris_game_ctrl #(
    .TICK_DIV(TICK_DIV), .ROWS(ROWS), .LOCK_DELAY(LOCK_DLY),
    .SPEED_INIT(SPD_INIT), .LINES_PER_LEVEL(LPL)
  ) dut (
    .iVGA_CLK(clk), .iRST_N(rst_n), .start_n(start_n), .rand_in(rand_in),
    .landed(landed), .spawn_blocked(spawn_blocked), .lock_done(lock_done),
    .row_full(row_full), .shift_done(shift_done), .shape(shape),
    .next_shape(next_shape), .change_shape(change_shape), .start_over(start_over),
    .clear(clear), .gravity_tick(gravity_tick), .lock_req(lock_req),
    .row_addr(row_addr), .shift_req(shift_req), .shift_row(shift_row),
    .speed(speed), .lines(lines), .game_over(game_over), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] piece_of(input logic [3:0] r);
    return (r > 4'd14) ? 4'd0 : r;
  endfunction

  function automatic int speed_of(input int l);
    int s;
    s = SPD_INIT + 2 * (l / LPL);
    return (s > 31) ? 31 : s;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_shapes"}, {shape, next_shape}, 0);
    chk({tag, "_pulses"}, {change_shape, start_over, clear, gravity_tick}, 0);
    chk({tag, "_reqs"}, {lock_req, shift_req, game_over}, 0);
    chk({tag, "_rows"}, {row_addr, shift_row}, 0);
    chk({tag, "_speed"}, speed, SPD_INIT);
    chk({tag, "_lines"}, lines, 0);
  endtask

  // Called in the first SPAWN cycle; r is the LFSR value present at spawn entry.
  task automatic check_spawn(input logic [3:0] r);
    chk("spawn_state", state, 1);
    chk("spawn_shape", shape, exp_next);
    chk("spawn_next", next_shape, piece_of(r));
    chk("spawn_pulses", {change_shape, start_over}, 2'b11);
    exp_next = piece_of(r);
  endtask

  task automatic do_start(input logic [3:0] r);
    start_n = 1'b0;
    rand_in = r;
    step();
    exp_lines = 0;
    check_spawn(r);
    chk("start_clears", {game_over, lines}, 0);
    chk("start_speed", speed, SPD_INIT);
    start_n = 1'b1;
  endtask

  // Plays one piece from its SPAWN cycle to the next SPAWN (or game over / reset).
  task automatic run_piece(input bit blocked, input logic [7:0] pat,
                           input logic [ROWS-1:0] mask, input logic [3:0] next_r,
                           input bit rst_in_lock);
    int cnt, lock_tick, nfull, k, n_clear, n_scan, cyc, w;
    int exp_rows[$];
    int sr;
    step();
    chk("chk_state", state, 2);
    chk("chk_pulses_off", {change_shape, start_over}, 0);
    spawn_blocked = blocked;
    step();
    spawn_blocked = 1'b0;
    if (blocked) begin
      chk("over_state", state, 7);
      chk("over_flag", game_over, 1);
      return;
    end
    chk("fall_state", state, 3);
    // Lock after LOCK_DLY consecutive landed ticks.
    cnt = 0;
    lock_tick = 0;
    for (int t = 1; t <= 8; t++) begin
      if (lock_tick == 0) begin
        cnt = pat[t-1] ? cnt + 1 : 0;
        if (cnt == LOCK_DLY) lock_tick = t;
      end
    end
    for (int t = 1; t <= lock_tick; t++) begin
      landed = pat[t-1];
      for (int c = 1; c <= TICK_DIV; c++) begin
        if (c == 2) lock_done = 1'b1;
        step();
        lock_done = 1'b0;
        chk("gravity_tick", gravity_tick, (c == TICK_DIV) ? 1 : 0);
        chk("lock_req_fall", lock_req, (t == lock_tick && c == TICK_DIV) ? 1 : 0);
      end
      chk("tick_state", state, (t == lock_tick) ? 4 : 3);
    end
    landed = 1'b0;
    if (rst_in_lock) begin
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      step();
      rst_n = 1'b1;
      exp_next = 4'd0;
      exp_lines = 0;
      step();
      check_reset_outputs("rst_rel");
      return;
    end
    w = $urandom_range(0, 3);
    for (int i = 0; i < w; i++) begin
      step();
      chk("lock_hold", {state, lock_req}, {3'd4, 1'b1});
    end
    lock_done = 1'b1;
    step();
    lock_done = 1'b0;
    chk("lock_drop", {state, lock_req}, {3'd5, 1'b0});
    chk("scan_top", row_addr, ROWS - 1);
    board = mask;
    rand_in = next_r;
    nfull = $countones(mask);
    for (int r = ROWS - 1; r >= 0; r--) if (mask[r]) exp_rows.push_back(r);
    k = 0; n_clear = 0; n_scan = 0; cyc = 0;
    while (state != 3'd1 && cyc < 400) begin
      cyc++;
      if (state == 3'd6) begin
        chk("shift_req", shift_req, 1);
        chk("shift_row", shift_row, (k < nfull) ? exp_rows[k] + k : 99);
        repeat ($urandom_range(0, 2)) begin
          step();
          cyc++;
          if (clear) n_clear++;
        end
        shift_done = 1'b1;
        step();
        shift_done = 1'b0;
        sr = int'(shift_row);
        for (int r = sr; r > 0; r--) if (r < ROWS) board[r] = board[r-1];
        board[0] = 1'b0;
        k++;
        exp_lines = (exp_lines < 65535) ? exp_lines + 1 : 65535;
        if (clear) n_clear++;
        chk("clear_pulse", clear, 1);
        chk("shift_drop", {state, shift_req}, {3'd5, 1'b0});
        chk("lines_inc", lines, exp_lines);
        chk("speed_lvl", speed, speed_of(exp_lines));
      end else begin
        n_scan++;
        if (cyc == 3) shift_done = 1'b1;
        step();
        shift_done = 1'b0;
        if (clear) n_clear++;
      end
    end
    chk("scan_end_spawn", state, 1);
    chk("clear_count", n_clear, nfull);
    chk("scan_cycles", n_scan, ROWS + nfull);
    check_spawn(next_r);
    chk("piece_lines", lines, exp_lines);
    chk("piece_speed", speed, speed_of(exp_lines));
  endtask

  initial begin
    logic [ROWS-1:0] m;
    logic [3:0] held;
    rst_n = 1'b0; start_n = 1'b1; rand_in = 4'd0; landed = 1'b0;
    spawn_blocked = 1'b0; lock_done = 1'b0; shift_done = 1'b0; board = '0;
    exp_next = 4'd0; exp_lines = 0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_hold", state, 0);

    do_start(4'd3);
    // landed on ticks 1,3,4 -> lock after tick 4; only row 23 full
    run_piece(1'b0, 8'b1100_1101, 24'h80_0000, 4'($urandom_range(0, 15)), 1'b0);
    // double clear: rows 23 and 20
    run_piece(1'b0, 8'hFF, 24'h90_0000, 4'($urandom_range(0, 15)), 1'b0);
    // completely full board: every removal is at row 23
    run_piece(1'b0, 8'($urandom) | 8'hC0, 24'hFF_FFFF, 4'($urandom_range(0, 15)), 1'b0);
    for (int p = 0; p < 8; p++) begin
      m = ROWS'($urandom & $urandom & $urandom);
      run_piece(1'b0, 8'($urandom) | 8'hC0, m, 4'($urandom_range(0, 15)), 1'b0);
    end
    chk("speed_sat", speed, 31);
    // next spawn draws 15, which must map to the square
    run_piece(1'b0, 8'($urandom) | 8'hC0, 24'h00_0001, 4'd15, 1'b0);
    held = shape;
    run_piece(1'b1, 8'h00, '0, 4'd0, 1'b0);
    repeat (4) step();
    chk("over_hold", {state, game_over, lock_req, shift_req}, {3'd7, 1'b1, 2'b00});
    chk("over_shape", shape, held);

    do_start(4'($urandom_range(0, 15)));
    run_piece(1'b0, 8'($urandom) | 8'hC0, '0, 4'd0, 1'b1);

    do_start(4'd9);
    run_piece(1'b0, 8'($urandom) | 8'hC0, 24'h00_0300, 4'd14, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
